twos_comp_serializer: RTL and testbench

Parallel-to-serial transmitter that feeds the serial two's complementer. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock, on `data_Out`. `sync_Out` is high on the first bit of each word so the downstream complementer restarts its carry state at each word boundary. Back-to-back words stream with no idle cycle between them.

---
 rtl/twos_comp_serializer.sv | 171 +++++++++++++++++
 tb/tb_twos_comp_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/twos_comp_serializer.sv
// LSB-first parallel-to-serial feeder for the serial two's complementer.
// Optional even-parity trailer bit is built when TWOS_SER_PARITY_EN is defined.
module twos_comp_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_In,
  input  logic             word_Valid,
  output logic             word_Ready,
  output logic             data_Out,
  output logic             sync_Out,
  output logic             bit_Valid,
  output logic             done,
  output logic [1:0]       State_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01
`ifdef TWOS_SER_PARITY_EN
    ,
    PARITY = 2'b10
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             data_q, data_d;
  logic             sync_q, sync_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             accept;
`ifdef TWOS_SER_PARITY_EN
  logic             parBit_q, parBit_d;
`endif

  assign accept = word_Valid && word_Ready;

  // Ready is offered in IDLE and in the final cycle of a word, so words chain without a gap.
  always_comb begin
    word_Ready = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:   word_Ready = 1'b1;
`ifdef TWOS_SER_PARITY_EN
        SHIFT:  word_Ready = 1'b0;
        PARITY: word_Ready = 1'b1;
`else
        SHIFT:  word_Ready = (cnt_q == LAST_CNT);
`endif
        default: word_Ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
`ifdef TWOS_SER_PARITY_EN
    parBit_d = parBit_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = word_In;
`ifdef TWOS_SER_PARITY_EN
          parBit_d = ^word_In;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_CNT) begin
`ifdef TWOS_SER_PARITY_EN
          state_d = PARITY;
`else
          if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            shift_d = word_In;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shift_d = shift_q >> 1;
        end
      end
`ifdef TWOS_SER_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          shift_d  = word_In;
          parBit_d = ^word_In;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Serial outputs are registered, so derive them from the state being entered.
  always_comb begin
    data_d  = 1'b0;
    sync_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      SHIFT: begin
        valid_d = 1'b1;
        data_d  = shift_d[0];
        sync_d  = (cnt_d == '0);
`ifndef TWOS_SER_PARITY_EN
        done_d  = (cnt_d == LAST_CNT);
`endif
      end
`ifdef TWOS_SER_PARITY_EN
      PARITY: begin
        valid_d = 1'b1;
        data_d  = parBit_d;
        done_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= 1'b0;
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef TWOS_SER_PARITY_EN
      parBit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      sync_q  <= sync_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef TWOS_SER_PARITY_EN
      parBit_q <= parBit_d;
`endif
    end
  end

  assign data_Out  = data_q;
  assign sync_Out  = sync_q;
  assign bit_Valid = valid_q;
  assign done      = done_q;
  assign State_out = state_q;

endmodule

// File: tb/tb_twos_comp_serializer.sv
// Scoreboard bench for twos_comp_serializer at WIDTH=4.
// Expected bits are queued at each handshake and popped every cycle by the monitor.
module tb_twos_comp_serializer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] word_In;
  logic             word_Valid;
  logic             word_Ready;
  logic             data_Out;
  logic             sync_Out;
  logic             bit_Valid;
  logic             done;
  logic [1:0]       State_out;

  typedef struct packed {
    logic       data;
    logic       sync;
    logic       done;
    logic [1:0] st;
  } bitExp_t;

  bitExp_t sb[$];
  int      checkCount = 0;
  int      failCount  = 0;
  bit      monOn      = 1'b0;

  twos_comp_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .word_In    (word_In),
    .word_Valid (word_Valid),
    .word_Ready (word_Ready),
    .data_Out   (data_Out),
    .sync_Out   (sync_Out),
    .bit_Valid  (bit_Valid),
    .done       (done),
    .State_out  (State_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void pushWord(input logic [WIDTH-1:0] w);
    bitExp_t e;
    for (int i = 0; i < WIDTH; i++) begin
      e.data = w[i];
      e.sync = (i == 0);
`ifdef TWOS_SER_PARITY_EN
      e.done = 1'b0;
`else
      e.done = (i == WIDTH - 1);
`endif
      e.st   = 2'b01;
      sb.push_back(e);
    end
`ifdef TWOS_SER_PARITY_EN
    e.data = ^w;
    e.sync = 1'b0;
    e.done = 1'b1;
    e.st   = 2'b10;
    sb.push_back(e);
`endif
  endfunction

  // A sampled reset drops whatever was still pending for the partial word.
  always @(posedge clk) begin
    if (reset) sb.delete();
  end

  always @(negedge clk) begin
    bitExp_t e;
    if (monOn) begin
      checkOutput("ready", {31'b0, word_Ready}, {31'b0, (!reset && sb.size() <= 1)});
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("bitValid", {31'b0, bit_Valid}, 32'd1);
        checkOutput("data",     {31'b0, data_Out},  {31'b0, e.data});
        checkOutput("sync",     {31'b0, sync_Out},  {31'b0, e.sync});
        checkOutput("done",     {31'b0, done},      {31'b0, e.done});
        checkOutput("state",    {30'b0, State_out}, {30'b0, e.st});
      end else begin
        checkOutput("idleValid", {31'b0, bit_Valid}, 32'd0);
        checkOutput("idleData",  {31'b0, data_Out},  32'd0);
        checkOutput("idleSync",  {31'b0, sync_Out},  32'd0);
        checkOutput("idleDone",  {31'b0, done},      32'd0);
        checkOutput("idleState", {30'b0, State_out}, 32'd0);
      end
    end
  end

  // Holds word_Valid high until the DUT accepts; scramble wiggles word_In while not ready.
  task automatic applyStimulus(input logic [WIDTH-1:0] w, input bit scramble);
    int waited = 0;
    bit taken  = 1'b0;
    word_Valid = 1'b1;
    word_In    = scramble ? WIDTH'($urandom) : w;
    while (!taken && waited < 20) begin
      @(negedge clk);
      #1;
      if (word_Ready) begin
        word_In = w;
        pushWord(w);
        taken = 1'b1;
      end else if (scramble) begin
        word_In = WIDTH'($urandom);
      end
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("accepted", {31'b0, taken}, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    word_Valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int waited;
    reset      = 1'b1;
    word_Valid = 1'b0;
    word_In    = '0;
    @(posedge clk);
    #1;
    monOn = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    idleCycles(10);

    applyStimulus(4'b0110, 1'b0);
    idleCycles(6);

    applyStimulus(4'hA, 1'b0);
    applyStimulus(4'h3, 1'b0);
    idleCycles(6);

    applyStimulus(4'h5, 1'b0);
    applyStimulus(4'h9, 1'b1);
    applyStimulus(4'hC, 1'b1);
    idleCycles(6);

    applyStimulus(4'hF, 1'b0);
    word_Valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset      = 1'b1;
    word_Valid = 1'b1;
    word_In    = 4'h9;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    word_Valid = 1'b0;
    idleCycles(3);

    applyStimulus(4'h1, 1'b0);
    idleCycles(6);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(WIDTH'($urandom), ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end

    word_Valid = 1'b0;
    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("drained", sb.size(), 32'd0);
    idleCycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
